// File: rtl/lcd_dma_fetch_ctrl.sv
// LCD DMA burst-fetch sequencer: turns FIFO watermark requests into
// fixed-length bus read bursts over the upper/lower panel frame buffers.
// Ports: clk, rst (sync active-low); config lcd_en, lcdtft, dual,
// watermark, upbase, lpbase, frame_words; FIFO side dma_req, fifofull,
// push, push_data; bus master bus_req/addr/len/gnt/rvalid/rdata/err;
// status panel_sel, frame_done, err_irq; frame sync fp_pulse.
// Option: define LCD_DMA_TIMEOUT_EN for an 8-bit bus watchdog.
module lcd_dma_fetch_ctrl #(
  parameter int ADDR_W = 32,
  parameter int FW_W   = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lcd_en,
  input  logic              lcdtft,
  input  logic              dual,
  input  logic              watermark,
  input  logic [ADDR_W-1:0] upbase,
  input  logic [ADDR_W-1:0] lpbase,
  input  logic [FW_W-1:0]   frame_words,
  input  logic              dma_req,
  input  logic              fifofull,
  input  logic              fp_pulse,
  output logic              bus_req,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_len,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_err,
  output logic              push,
  output logic [31:0]       push_data,
  output logic              panel_sel,
  output logic              frame_done,
  output logic              err_irq
);

  typedef enum logic [2:0] {
    IDLE, ARB, REQ, XFER, FLUSH
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] up_addr, lp_addr, cur_addr;
  logic [FW_W-1:0]   up_rem, lp_rem, cur_rem, arb_rem;
  logic [3:0]        beat_cnt, burst, len_arb, step;
  logic              alt, fp_pend, dual_mode, sel_arb;
  logic              beat, last, adv, wrap, ending;
  logic              reload_all, to;

`ifdef LCD_DMA_TIMEOUT_EN
  logic [7:0] wd;
  logic       stall;

  assign stall = (state == REQ || state == XFER) &&
                 !bus_gnt && !bus_rvalid;
  // trips on the 255th consecutive stalled cycle
  assign to = stall && (wd == 8'd254);

  always_ff @(posedge clk) begin
    if (!rst)
      wd <= '0;
    else if (stall && !to)
      wd <= wd + 8'd1;
    else
      wd <= '0;
  end
`else
  assign to = 1'b0;
`endif

  always_comb begin
    dual_mode = !lcdtft && dual;
    sel_arb   = dual_mode && alt;
    arb_rem   = sel_arb ? lp_rem : up_rem;
    burst     = watermark ? 4'd8 : 4'd4;
    len_arb   = burst;
    if (arb_rem < FW_W'(burst))
      len_arb = arb_rem[3:0];
    cur_addr  = panel_sel ? lp_addr : up_addr;
    cur_rem   = panel_sel ? lp_rem : up_rem;
    // grant-cycle beats are ignored: only XFER/FLUSH count beats
    beat      = bus_rvalid && (state == XFER || state == FLUSH);
    last      = beat && (beat_cnt == 4'd1);
    ending    = last || to;
    // a watchdog abort skips every unfetched beat at once
    step      = to ? beat_cnt : 4'd1;
    wrap      = cur_rem <= FW_W'(step);
    // after a frame pulse the flushed beats are thrown away with
    // the stale addresses, so they do not advance anything
    adv       = to || (beat && !fp_pend);
    reload_all = (fp_pulse && (state == IDLE || state == ARB ||
                               state == REQ)) ||
                 (ending && (fp_pend || fp_pulse));
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (!fp_pulse && lcd_en && dma_req && !fifofull)
          state_nxt = ARB;
      ARB:
        if (fp_pulse || !lcd_en) state_nxt = IDLE;
        else                     state_nxt = REQ;
      REQ:
        if (fp_pulse || to) state_nxt = IDLE;
        else if (bus_gnt)   state_nxt = XFER;
      XFER:
        if (ending)
          state_nxt = IDLE;
        else if ((beat && bus_err) || fp_pulse)
          state_nxt = FLUSH;
      FLUSH:
        if (last) state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus_req   = (state == REQ);
    push      = (state == XFER) && bus_rvalid && !bus_err;
    push_data = push ? bus_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      up_addr    <= upbase;
      lp_addr    <= lpbase;
      up_rem     <= frame_words;
      lp_rem     <= frame_words;
      alt        <= 1'b0;
      fp_pend    <= 1'b0;
      beat_cnt   <= '0;
      bus_addr   <= '0;
      bus_len    <= '0;
      panel_sel  <= 1'b0;
      frame_done <= 1'b0;
      err_irq    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      err_irq    <= 1'b0;
      if (state == ARB && state_nxt == REQ) begin
        panel_sel <= sel_arb;
        bus_addr  <= sel_arb ? lp_addr : up_addr;
        bus_len   <= len_arb;
        beat_cnt  <= len_arb;
        if (dual_mode) alt <= !sel_arb;
      end
      if (beat)
        beat_cnt <= beat_cnt - 4'd1;
      if ((state == XFER && beat && bus_err) || to)
        err_irq <= 1'b1;
      if ((state == XFER || state == FLUSH) && fp_pulse && !ending)
        fp_pend <= 1'b1;
      if (adv) begin
        if (wrap) begin
          frame_done <= 1'b1;
          if (panel_sel) begin
            lp_addr <= lpbase;
            lp_rem  <= frame_words;
          end else begin
            up_addr <= upbase;
            up_rem  <= frame_words;
          end
        end else if (panel_sel) begin
          lp_addr <= cur_addr + ADDR_W'({step, 2'b00});
          lp_rem  <= cur_rem - FW_W'(step);
        end else begin
          up_addr <= cur_addr + ADDR_W'({step, 2'b00});
          up_rem  <= cur_rem - FW_W'(step);
        end
      end
      if (reload_all) begin
        up_addr <= upbase;
        lp_addr <= lpbase;
        up_rem  <= frame_words;
        lp_rem  <= frame_words;
        alt     <= 1'b0;
        fp_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lcd_dma_fetch_ctrl.sv
// Scoreboard bench for lcd_dma_fetch_ctrl: stimulus queues expected
// bursts/pushes, a negedge monitor pops and compares them.
module tb_lcd_dma_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        lcd_en = 1'b0, lcdtft = 1'b1, dual = 1'b0;
  logic        watermark = 1'b1;
  logic [31:0] upbase = '0, lpbase = '0;
  logic [19:0] frame_words = 20'd16;
  logic        dma_req = 1'b0, fifofull = 1'b0, fp_pulse = 1'b0;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic [3:0]  bus_len;
  logic        bus_gnt = 1'b0, bus_rvalid = 1'b0, bus_err = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        push;
  logic [31:0] push_data;
  logic        panel_sel, frame_done, err_irq;

  always #5 clk = ~clk;

  lcd_dma_fetch_ctrl #(.ADDR_W(32), .FW_W(20)) dut (
    .clk(clk), .rst(rst), .lcd_en(lcd_en), .lcdtft(lcdtft),
    .dual(dual), .watermark(watermark), .upbase(upbase),
    .lpbase(lpbase), .frame_words(frame_words), .dma_req(dma_req),
    .fifofull(fifofull), .fp_pulse(fp_pulse), .bus_req(bus_req),
    .bus_addr(bus_addr), .bus_len(bus_len), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .bus_err(bus_err), .push(push), .push_data(push_data),
    .panel_sel(panel_sel), .frame_done(frame_done),
    .err_irq(err_irq)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [3:0]  l;
    logic        p;
  } req_t;

  req_t        exp_req[$];
  logic [31:0] exp_push[$];
  req_t        mr;
  int n_cmp = 0, n_bad = 0, fd_cnt = 0, err_cnt = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] dat(logic [31:0] a, int i);
    return (a + 32'(4 * i)) ^ 32'hA5A5_0000;
  endfunction

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (err_irq) err_cnt++;
    if (bus_req && bus_gnt) begin
      if (exp_req.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL extra_grant: got addr %h want none", bus_addr);
      end else begin
        mr = exp_req.pop_front();
        chk("bus_addr", bus_addr, mr.a);
        chk("bus_len", 32'(bus_len), 32'(mr.l));
        chk("panel_sel", 32'(panel_sel), 32'(mr.p));
      end
    end
    if (push) begin
      if (exp_push.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL extra_push: got %h want none", push_data);
      end else
        chk("push_data", push_data, exp_push.pop_front());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic burst(input logic [31:0] ea, input logic [3:0] el,
                       input logic ep, input int nb,
                       input int errb, input int fpb);
    req_t e;
    int   t;
    e.a = ea; e.l = el; e.p = ep;
    exp_req.push_back(e);
    for (int i = 0; i < nb; i++)
      if (i < errb && i < fpb) exp_push.push_back(dat(ea, i));
    t = 0;
    while (!bus_req && t < 50) begin
      cyc();
      t++;
    end
    if (!bus_req) begin
      n_cmp++; n_bad++;
      $display("FAIL req_timeout: got no bus_req want addr %h", ea);
      return;
    end
    bus_gnt = 1'b1;
    cyc();
    bus_gnt = 1'b0;
    for (int i = 0; i < nb; i++) begin
      if (i == fpb) begin
        fp_pulse = 1'b1;
        cyc();
        fp_pulse = 1'b0;
      end else if (i % 3 == 1) begin
        cyc();
      end
      bus_rvalid = 1'b1;
      bus_rdata  = dat(ea, i);
      bus_err    = (i == errb);
      cyc();
      bus_rvalid = 1'b0;
      bus_err    = 1'b0;
    end
  endtask

  task automatic fp_reset();
    dma_req = 1'b0;
    cyc();
    fp_pulse = 1'b1;
    cyc();
    fp_pulse = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic end_chk(string nm, int fd_exp, int err_exp);
    dma_req = 1'b0;
    repeat (4) cyc();
    chk({nm, "_frame_done"}, 32'(fd_cnt), 32'(fd_exp));
    chk({nm, "_err_irq"}, 32'(err_cnt), 32'(err_exp));
    chk({nm, "_req_left"}, 32'(exp_req.size()), 32'd0);
    chk({nm, "_push_left"}, 32'(exp_push.size()), 32'd0);
  endtask

  task automatic rst_chk(string nm);
    chk({nm, "_bus_req"}, 32'(bus_req), 32'd0);
    chk({nm, "_push"}, 32'(push), 32'd0);
    chk({nm, "_push_data"}, push_data, 32'd0);
    chk({nm, "_bus_addr"}, bus_addr, 32'd0);
    chk({nm, "_bus_len"}, 32'(bus_len), 32'd0);
    chk({nm, "_panel_sel"}, 32'(panel_sel), 32'd0);
    chk({nm, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({nm, "_err_irq"}, 32'(err_irq), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    lcd_en = 1'b1;
    upbase = 32'h1000;
    lpbase = 32'h5000;
    repeat (2) cyc();
    rst_chk("reset");
    rst = 1'b1;

    // single-panel TFT, 8-beat bursts, 16-word frame
    dma_req = 1'b1;
    cyc();
    chk("lat_arb", 32'(bus_req), 32'd0);
    cyc();
    chk("lat_req", 32'(bus_req), 32'd1);
    burst(32'h1000, 4'd8, 1'b0, 8, 99, 99);
    burst(32'h1020, 4'd8, 1'b0, 8, 99, 99);
    burst(32'h1000, 4'd8, 1'b0, 8, 99, 99);
    end_chk("tft", 1, 0);

    // dual-panel STN, 4-beat bursts alternate panels
    lcdtft = 1'b0; dual = 1'b1; watermark = 1'b0;
    upbase = 32'h2000; lpbase = 32'h3000;
    fp_reset();
    dma_req = 1'b1;
    burst(32'h2000, 4'd4, 1'b0, 4, 99, 99);
    burst(32'h3000, 4'd4, 1'b1, 4, 99, 99);
    burst(32'h2010, 4'd4, 1'b0, 4, 99, 99);
    burst(32'h3010, 4'd4, 1'b1, 4, 99, 99);
    end_chk("dual", 1, 0);

    // truncated burst at end of a 10-word frame
    lcdtft = 1'b1; dual = 1'b0; watermark = 1'b1;
    upbase = 32'h1000; frame_words = 20'd10;
    fp_reset();
    dma_req = 1'b1;
    cyc();
    chk("lat2_arb", 32'(bus_req), 32'd0);
    cyc();
    chk("lat2_req", 32'(bus_req), 32'd1);
    burst(32'h1000, 4'd8, 1'b0, 8, 99, 99);
    burst(32'h1020, 4'd2, 1'b0, 2, 99, 99);
    burst(32'h1000, 4'd8, 1'b0, 8, 99, 99);
    end_chk("trunc", 2, 0);

    // bus error on beat 3: two pushes, address still advances by 32
    frame_words = 20'd16; upbase = 32'h4000;
    fp_reset();
    dma_req = 1'b1;
    burst(32'h4000, 4'd8, 1'b0, 8, 2, 99);
    burst(32'h4020, 4'd8, 1'b0, 8, 99, 99);
    end_chk("buserr", 3, 1);

    // frame pulse after beat 2: flush, restart at upper base
    lcdtft = 1'b0; dual = 1'b1;
    upbase = 32'h6000; lpbase = 32'h7000;
    fp_reset();
    dma_req = 1'b1;
    burst(32'h6000, 4'd8, 1'b0, 8, 99, 2);
    burst(32'h6000, 4'd8, 1'b0, 8, 99, 99);
    end_chk("fpmid", 3, 1);

    // reset in the middle of a burst
    lcdtft = 1'b1; dual = 1'b0; upbase = 32'h8000;
    fp_reset();
    dma_req = 1'b1;
    burst(32'h8000, 4'd8, 1'b0, 2, 99, 99);
    rst = 1'b0;
    cyc();
    rst_chk("midrst");
    rst = 1'b1;
    burst(32'h8000, 4'd8, 1'b0, 8, 99, 99);
    end_chk("midrst", 3, 1);

`ifdef LCD_DMA_TIMEOUT_EN
    begin
      int e0;
      int t;
      fp_reset();
      dma_req = 1'b1;
      t = 0;
      while (!bus_req && t < 50) begin
        cyc();
        t++;
      end
      e0 = err_cnt;
      repeat (262) cyc();
      chk("watchdog_err", 32'(err_cnt - e0), 32'd1);
      fp_reset();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
